serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_seq.sv | 133 +++++++++++++
 tb/tb_serial_adder_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: feeds operand bit pairs LSB first through a
// 1-bit full adder, registering the carry between bits.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic load;
    logic step;
    logic last_bit;
    logic fa_s;
    logic fa_co;

    serial_adder_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DONE lasts exactly one cycle; a start seen there chains straight into RUN.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last_bit = (cnt == LAST_BIT);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sr  <= op_a;
            b_sr  <= op_b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= fa_co;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            if (last_bit) begin
                // Publish the finished word; it is held until the next completion.
                sum_q  <= {fa_s, res_sr[WIDTH-1:1]};
                cout_q <= fa_co;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized self-checking bench for serial_adder_seq against an arithmetic model.

module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors;
    int checks;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole addition done at once in W+1 bits.
    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Starts one addition and observes W+3 cycles after the accepted edge.
    // Optionally re-pulses start (with junk operands) at observation cycle 'poke'.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input int poke,
                           output logic [W-1:0] got_sum, output logic got_cout,
                           output int busy_cnt, output int done_cnt, output int done_at,
                           output int early_drop, output int held_bad);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        @(negedge clk);
        op_a      = a;
        op_b      = b;
        cin       = ci;
        start     = 1'b1;
        prev_sum  = sum;
        prev_cout = cout;
        @(posedge clk);
        #1;
        start      = 1'b0;
        op_a       = W'($urandom);
        op_b       = W'($urandom);
        cin        = 1'($urandom);
        busy_cnt   = 0;
        done_cnt   = 0;
        done_at    = -1;
        early_drop = 0;
        held_bad   = 0;
        got_sum    = sum;
        got_cout   = cout;
        for (int j = 0; j < W + 3; j++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (j < W && busy !== 1'b1) early_drop++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at  = j;
                    got_sum  = sum;
                    got_cout = cout;
                end
            end
            if (done_at < 0 && (sum !== prev_sum || cout !== prev_cout)) held_bad++;
            if (j == poke) begin
                start = 1'b1;
                op_a  = '1;
                op_b  = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
                     busy, done, sum, cout);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle: cycle %0d busy=%b done=%b, required 0 0",
                         j, busy, done);
            end
        end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci,
                                 input logic [W-1:0] exp_sum, input logic exp_cout);
        logic [W-1:0] s;
        logic         c;
        int bc, dc, da, ed, hb;
        run_add(a, b, ci, -1, s, c, bc, dc, da, ed, hb);
        checks++;
        if (s !== exp_sum || c !== exp_cout) begin
            errors++;
            $display("[TB] FAIL %s_result: got sum=%h cout=%b, required sum=%h cout=%b",
                     name, s, c, exp_sum, exp_cout);
        end
        checks++;
        if (bc !== W || ed !== 0) begin
            errors++;
            $display("[TB] FAIL %s_busy: busy cycles=%0d early drops=%0d, required %0d and 0",
                     name, bc, ed, W);
        end
        checks++;
        if (dc !== 1 || da !== W) begin
            errors++;
            $display("[TB] FAIL %s_done: pulses=%0d at=%0d, required 1 at %0d",
                     name, dc, da, W);
        end
        checks++;
        if (hb !== 0) begin
            errors++;
            $display("[TB] FAIL %s_hold: result changed %0d times before done, required 0",
                     name, hb);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic         ci, c;
        logic [W:0]   exp;
        int bc, dc, da, ed, hb;
        for (int n = 0; n < 16; n++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            ci  = 1'($urandom);
            exp = model_add(a, b, ci);
            run_add(a, b, ci, -1, s, c, bc, dc, da, ed, hb);
            checks++;
            if ({c, s} !== exp || dc !== 1 || da !== W || bc !== W) begin
                errors++;
                $display("[TB] FAIL random_%0d: %h+%h+%b got cout=%b sum=%h done=%0d@%0d busy=%0d, required cout=%b sum=%h done=1@%0d busy=%0d",
                         n, a, b, ci, c, s, dc, da, bc, exp[W], exp[W-1:0], W, W);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] s;
        logic         c;
        int bc, dc, da, ed, hb;
        run_add(8'h10, 8'h20, 1'b0, 2, s, c, bc, dc, da, ed, hb);
        checks++;
        if (s !== 8'h30 || c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignored_start_result: got sum=%h cout=%b, required 30 0", s, c);
        end
        checks++;
        if (dc !== 1 || da !== W || ed !== 0 || bc !== W) begin
            errors++;
            $display("[TB] FAIL ignored_start_timing: done=%0d@%0d busy=%0d drops=%0d, required 1@%0d busy=%0d drops=0",
                     dc, da, bc, ed, W, W);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int busy_bad;
        int hold_bad;
        int done_bad;
        logic [W:0] exp2;
        exp2       = model_add(8'h80, 8'h80, 1'b1);
        first_done = 0;
        busy_bad   = 0;
        hold_bad   = 0;
        done_bad   = 0;
        @(negedge clk);
        op_a  = 8'h10;
        op_b  = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j <= W; j++) begin
            @(negedge clk);
            if (j == W && done === 1'b1 && sum === 8'h30) first_done = 1;
        end
        checks++;
        if (first_done !== 1) begin
            errors++;
            $display("[TB] FAIL b2b_first: done=%b sum=%h, required 1 30", done, sum);
        end
        op_a  = 8'h80;
        op_b  = 8'h80;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        for (int j = 0; j <= W; j++) begin
            @(negedge clk);
            if (j < W) begin
                if (busy !== 1'b1) busy_bad++;
                if (done !== 1'b0) done_bad++;
                if (sum !== 8'h30 || cout !== 1'b0) hold_bad++;
            end else begin
                checks++;
                if (done !== 1'b1 || {cout, sum} !== exp2) begin
                    errors++;
                    $display("[TB] FAIL b2b_second: done=%b cout=%b sum=%h, required 1 %b %h",
                             done, cout, sum, exp2[W], exp2[W-1:0]);
                end
            end
        end
        checks++;
        if (busy_bad !== 0 || done_bad !== 0 || hold_bad !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_run: busy gaps=%0d stray done=%0d hold errs=%0d, required 0 0 0",
                     busy_bad, done_bad, hold_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s;
        logic         c;
        int bc, dc, da, ed, hb;
        int stray_done;
        stray_done = 0;
        @(negedge clk);
        op_a  = 8'h33;
        op_b  = 8'h44;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 0; j < 3; j++) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
                     busy, done, sum, cout);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
        end
        rst_n = 1'b1;
        for (int j = 0; j < W + 2; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
        end
        checks++;
        if (stray_done !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_quiet: %0d cycles with busy/done, required 0", stray_done);
        end
        run_add(8'h01, 8'h01, 1'b0, -1, s, c, bc, dc, da, ed, hb);
        checks++;
        if (s !== 8'h02 || c !== 1'b0 || dc !== 1 || da !== W) begin
            errors++;
            $display("[TB] FAIL reset_mid_after: sum=%h cout=%b done=%0d@%0d, required 02 0 1@%0d",
                     s, c, dc, da, W);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        cin    = 1'b0;
        test_reset();
        test_directed("basic", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
        test_directed("carry_ff", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        test_directed("carry_a5", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
